// File: rtl/apb_bridge_pkg.sv
// Shared types and address map for the AHB-to-APB bridge.
package apb_bridge_pkg;

  localparam int NUM_SLV = 3;

  // Each peripheral owns one 64 MB window; index i selects pselx[i].
  localparam logic [31:0] SLV_MASK = 32'hFC00_0000;
  localparam logic [NUM_SLV-1:0][31:0] SLV_BASE = {
    32'h8800_0000, 32'h8400_0000, 32'h8000_0000
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

endpackage

// File: rtl/apb_master_ctrl_if.sv
// Request/response handshake plus APB2 bus bundle for apb_master_ctrl.
interface apb_master_ctrl_if #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NUM_SLV = 3
);
  logic              req_valid;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              req_ready;

  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  logic [NUM_SLV-1:0] pselx;
  logic               penable;
  logic               pwrite;
  logic [ADDR_W-1:0]  paddr;
  logic [DATA_W-1:0]  pwdata;
  logic [DATA_W-1:0]  prdata;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, prdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           pselx, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, prdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           pselx, penable, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/apb_addr_decode.sv
// Combinational address -> one-hot peripheral select; shared with the AHB slave side.
module apb_addr_decode
  import apb_bridge_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int NUM_SLV = apb_bridge_pkg::NUM_SLV
) (
  input  logic [ADDR_W-1:0]  addr,
  output logic [NUM_SLV-1:0] sel,
  output logic               valid
);

  for (genvar i = 0; i < NUM_SLV; i++) begin : g_slv
    assign sel[i] = ((addr & ADDR_W'(SLV_MASK)) == ADDR_W'(SLV_BASE[i]));
  end

  assign valid = |sel;

endmodule

// File: rtl/apb_master_ctrl.sv
// APB2 initiator: SETUP/ACCESS sequencing, select decode and one-cycle response
// back to the AHB-side pipeline.
module apb_master_ctrl
  import apb_bridge_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NUM_SLV = apb_bridge_pkg::NUM_SLV
) (
  input logic               hclk,
  input logic               hresetn,
  apb_master_ctrl_if.master bus
);

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  typedef struct packed {
    logic              valid;
    logic              err;
    logic [DATA_W-1:0] rdata;
  } rsp_t;

  localparam rsp_t RSP_ERR = '{valid: 1'b1, err: 1'b1, rdata: '0};

  state_e             state_q, state_d;
  req_t               req_q, req_d;
  rsp_t               rsp_q, rsp_d;
  logic [NUM_SLV-1:0] psel_q, psel_d;
  logic               pen_q, pen_d;
  logic               err_pend_q, err_pend_d;

  logic [NUM_SLV-1:0] dec_sel;
  logic               dec_valid;
  logic               req_ready;
  logic               accept;
  req_t               req_in;

  apb_addr_decode #(.ADDR_W(ADDR_W), .NUM_SLV(NUM_SLV)) u_dec (
    .addr  (bus.req_addr),
    .sel   (dec_sel),
    .valid (dec_valid)
  );

  // Gated by hresetn so the port reads 0 while reset is held.
  assign req_ready = hresetn && (state_q != SETUP);
  assign accept    = bus.req_valid && req_ready;
  assign req_in    = '{write: bus.req_write, addr: bus.req_addr, wdata: bus.req_wdata};

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q    <= IDLE;
      req_q      <= '0;
      rsp_q      <= '0;
      psel_q     <= '0;
      pen_q      <= 1'b0;
      err_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      rsp_q      <= rsp_d;
      psel_q     <= psel_d;
      pen_q      <= pen_d;
      err_pend_q <= err_pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && dec_valid) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  state_d = (accept && dec_valid) ? SETUP : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_d      = req_q;
    rsp_d      = '0;
    psel_d     = '0;
    pen_d      = 1'b0;
    err_pend_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (err_pend_q) rsp_d = RSP_ERR;
        if (accept) begin
          if (dec_valid) begin
            req_d  = req_in;
            psel_d = dec_sel;
          end else if (err_pend_q) begin
            err_pend_d = 1'b1;
          end else begin
            rsp_d = RSP_ERR;
          end
        end
      end
      SETUP: begin
        psel_d = psel_q;
        pen_d  = 1'b1;
      end
      ACCESS: begin
        rsp_d.valid = 1'b1;
        rsp_d.rdata = req_q.write ? '0 : bus.prdata;
        // A bad address arriving at the ACCESS edge queues its error behind the success pulse.
        if (accept) begin
          if (dec_valid) begin
            req_d  = req_in;
            psel_d = dec_sel;
          end else begin
            err_pend_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_q.valid;
  assign bus.rsp_err   = rsp_q.err;
  assign bus.rsp_rdata = rsp_q.rdata;
  assign bus.pselx     = psel_q;
  assign bus.penable   = pen_q;
  assign bus.pwrite    = req_q.write;
  assign bus.paddr     = req_q.addr;
  assign bus.pwdata    = req_q.wdata;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Bench for apb_master_ctrl: directed waveform table, reset corner, and random
// traffic against a transaction-level schedule model.
module tb_apb_master_ctrl;

  localparam int NR = 400;

  logic hclk = 1'b0;
  logic hresetn = 1'b0;

  apb_master_ctrl_if #(.ADDR_W(32), .DATA_W(32), .NUM_SLV(3)) bus();

  apb_master_ctrl #(.ADDR_W(32), .DATA_W(32), .NUM_SLV(3)) dut (
    .hclk    (hclk),
    .hresetn (hresetn),
    .bus     (bus)
  );

  always #5 hclk = ~hclk;

  int n_pass = 0;
  int n_tot  = 0;

  typedef struct {
    logic        v, w;
    logic [31:0] a, d, pr;
    logic        rdy;
    logic [2:0]  ps;
    logic        pen, rv, re;
    logic [31:0] rd;
    logic        pwr;
    logic [31:0] pa, pwd;
  } vec_t;

  vec_t tbl[21];

  // Random-phase schedule: what each cycle must look like, indexed by cycle.
  logic [31:0] pr_a  [NR+8];
  bit          setup_c[NR+8];
  bit          rv_e  [NR+8];
  bit          re_e  [NR+8];
  logic [31:0] rd_e  [NR+8];
  logic [2:0]  ps_e  [NR+8];
  bit          pen_e [NR+8];
  logic        pwr_e [NR+8];
  logic [31:0] pa_e  [NR+8];
  logic [31:0] pwd_e [NR+8];
  logic [31:0] bnd   [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic drive(input logic v, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] pr);
    bus.req_valid = v;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.prdata    = pr;
  endtask

  task automatic chk_cyc(input string t, input logic rdy, input logic [2:0] ps,
                         input logic pen, input logic rv, input logic re,
                         input logic [31:0] rd, input logic pwr,
                         input logic [31:0] pa, input logic [31:0] pwd);
    chk({t, ".req_ready"}, 32'(bus.req_ready), 32'(rdy));
    chk({t, ".pselx"},     32'(bus.pselx),     32'(ps));
    chk({t, ".penable"},   32'(bus.penable),   32'(pen));
    chk({t, ".rsp_valid"}, 32'(bus.rsp_valid), 32'(rv));
    if (rv) begin
      chk({t, ".rsp_err"},   32'(bus.rsp_err), 32'(re));
      chk({t, ".rsp_rdata"}, bus.rsp_rdata,    rd);
    end
    if (ps != 3'b000) begin
      chk({t, ".pwrite"}, 32'(bus.pwrite), 32'(pwr));
      chk({t, ".paddr"},  bus.paddr,       pa);
      chk({t, ".pwdata"}, bus.pwdata,      pwd);
    end
  endtask

  task automatic chk_all_zero(input string t);
    chk({t, ".req_ready"}, 32'(bus.req_ready), 32'h0);
    chk({t, ".pselx"},     32'(bus.pselx),     32'h0);
    chk({t, ".penable"},   32'(bus.penable),   32'h0);
    chk({t, ".pwrite"},    32'(bus.pwrite),    32'h0);
    chk({t, ".paddr"},     bus.paddr,          32'h0);
    chk({t, ".pwdata"},    bus.pwdata,         32'h0);
    chk({t, ".rsp_valid"}, 32'(bus.rsp_valid), 32'h0);
    chk({t, ".rsp_err"},   32'(bus.rsp_err),   32'h0);
    chk({t, ".rsp_rdata"}, bus.rsp_rdata,      32'h0);
  endtask

  // Region index from plain address arithmetic; -1 outside the peripheral map.
  function automatic int model_dec(input logic [31:0] a);
    if (a >= 32'h8000_0000 && a < 32'h8C00_0000)
      return int'((a - 32'h8000_0000) / 32'h0400_0000);
    return -1;
  endfunction

  function automatic logic [31:0] pick_addr();
    int unsigned r;
    r = $urandom % 8;
    if (r < 4) return 32'h8000_0000 + ($urandom % 3) * 32'h0400_0000 + ($urandom & 32'h03FF_FFFF);
    if (r < 6) return bnd[$urandom % 8];
    return $urandom;
  endfunction

  logic        rv_v, rv_w;
  logic [31:0] rv_a, rv_d;
  int          idx, j;
  logic [2:0]  oh;

  initial begin
    bnd = '{32'h8000_0000, 32'h83FF_FFFF, 32'h8400_0000, 32'h87FF_FFFF,
            32'h8800_0000, 32'h8BFF_FFFF, 32'h7FFF_FFFF, 32'h8C00_0000};

    //         v  w  addr           wdata          prdata         rdy ps      pen rv re rdata          pwr paddr          pwdata
    tbl[0]  = '{1, 1, 32'h8000_0010, 32'hA5A5_A5A5, 32'h0,         0, 3'b001, 0, 0, 0, 32'h0,         1, 32'h8000_0010, 32'hA5A5_A5A5};
    tbl[1]  = '{0, 0, 32'h0,         32'h0,         32'h0,         1, 3'b001, 1, 0, 0, 32'h0,         1, 32'h8000_0010, 32'hA5A5_A5A5};
    tbl[2]  = '{0, 0, 32'h0,         32'h0,         32'h0,         1, 3'b000, 0, 1, 0, 32'h0,         0, 32'h0,         32'h0};
    tbl[3]  = '{0, 0, 32'h0,         32'h0,         32'h0,         1, 3'b000, 0, 0, 0, 32'h0,         0, 32'h0,         32'h0};
    tbl[4]  = '{1, 0, 32'h8400_0004, 32'h0,         32'h0,         0, 3'b010, 0, 0, 0, 32'h0,         0, 32'h8400_0004, 32'h0};
    tbl[5]  = '{0, 0, 32'h0,         32'h0,         32'hDEAD_BEEF, 1, 3'b010, 1, 0, 0, 32'h0,         0, 32'h8400_0004, 32'h0};
    tbl[6]  = '{0, 0, 32'h0,         32'h0,         32'h1234_0000, 1, 3'b000, 0, 1, 0, 32'h1234_0000, 0, 32'h0,         32'h0};
    tbl[7]  = '{0, 0, 32'h0,         32'h0,         32'h0,         1, 3'b000, 0, 0, 0, 32'h0,         0, 32'h0,         32'h0};
    tbl[8]  = '{1, 0, 32'h8800_0000, 32'h0,         32'h0,         0, 3'b100, 0, 0, 0, 32'h0,         0, 32'h8800_0000, 32'h0};
    tbl[9]  = '{1, 1, 32'h8000_0008, 32'h0BAD_F00D, 32'h0,         1, 3'b100, 1, 0, 0, 32'h0,         0, 32'h8800_0000, 32'h0};
    tbl[10] = '{1, 1, 32'h8000_0008, 32'h0BAD_F00D, 32'hCAFE_0001, 0, 3'b001, 0, 1, 0, 32'hCAFE_0001, 1, 32'h8000_0008, 32'h0BAD_F00D};
    tbl[11] = '{0, 0, 32'h0,         32'h0,         32'h0,         1, 3'b001, 1, 0, 0, 32'h0,         1, 32'h8000_0008, 32'h0BAD_F00D};
    tbl[12] = '{0, 0, 32'h0,         32'h0,         32'h0,         1, 3'b000, 0, 1, 0, 32'h0,         0, 32'h0,         32'h0};
    tbl[13] = '{0, 0, 32'h0,         32'h0,         32'h0,         1, 3'b000, 0, 0, 0, 32'h0,         0, 32'h0,         32'h0};
    tbl[14] = '{1, 0, 32'h9000_0000, 32'h0,         32'h0,         1, 3'b000, 0, 1, 1, 32'h0,         0, 32'h0,         32'h0};
    tbl[15] = '{0, 0, 32'h0,         32'h0,         32'h0,         1, 3'b000, 0, 0, 0, 32'h0,         0, 32'h0,         32'h0};
    tbl[16] = '{1, 1, 32'h8000_0020, 32'h1111_2222, 32'h0,         0, 3'b001, 0, 0, 0, 32'h0,         1, 32'h8000_0020, 32'h1111_2222};
    tbl[17] = '{1, 0, 32'h0,         32'h0,         32'h0,         1, 3'b001, 1, 0, 0, 32'h0,         1, 32'h8000_0020, 32'h1111_2222};
    tbl[18] = '{1, 0, 32'h0,         32'h0,         32'h0,         1, 3'b000, 0, 1, 0, 32'h0,         0, 32'h0,         32'h0};
    tbl[19] = '{0, 0, 32'h0,         32'h0,         32'h0,         1, 3'b000, 0, 1, 1, 32'h0,         0, 32'h0,         32'h0};
    tbl[20] = '{0, 0, 32'h0,         32'h0,         32'h0,         1, 3'b000, 0, 0, 0, 32'h0,         0, 32'h0,         32'h0};

    // Reset state
    drive(0, 0, 32'h0, 32'h0, 32'h0);
    #12;
    chk_all_zero("reset");
    tick();
    hresetn = 1'b1;
    tick();

    // Directed waveforms
    for (int i = 0; i < 21; i++) begin
      drive(tbl[i].v, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].pr);
      tick();
      chk_cyc($sformatf("vec%0d", i), tbl[i].rdy, tbl[i].ps, tbl[i].pen, tbl[i].rv,
              tbl[i].re, tbl[i].rd, tbl[i].pwr, tbl[i].pa, tbl[i].pwd);
    end

    // Reset asserted mid-ACCESS: transfer dropped, no response afterwards
    drive(1, 1, 32'h8400_0000, 32'h5555_AAAA, 32'h0);
    tick();
    drive(0, 0, 32'h0, 32'h0, 32'h0);
    tick();
    chk("rst_mid.in_access", 32'(bus.penable), 32'h1);
    #2;
    hresetn = 1'b0;
    #1;
    chk_all_zero("rst_mid.async");
    tick();
    tick();
    hresetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_cyc($sformatf("rst_after%0d", i), 1, 3'b000, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0);
    end

    // Random traffic against the schedule model
    for (int c = 0; c < NR + 8; c++) begin
      pr_a[c] = $urandom;
      setup_c[c] = 0; rv_e[c] = 0; re_e[c] = 0; rd_e[c] = 0;
      ps_e[c] = 0; pen_e[c] = 0; pwr_e[c] = 0; pa_e[c] = 0; pwd_e[c] = 0;
    end
    for (int k = 0; k < NR; k++) begin
      rv_v = (($urandom % 10) < 6);
      rv_w = 1'($urandom % 2);
      rv_a = pick_addr();
      rv_d = $urandom;
      drive(rv_v, rv_w, rv_a, rv_d, pr_a[k]);
      if (rv_v && !setup_c[k]) begin
        idx = model_dec(rv_a);
        if (idx >= 0) begin
          oh = 3'(1 << idx);
          setup_c[k+1] = 1;
          for (int s = 1; s <= 2; s++) begin
            ps_e[k+s]  = oh;
            pwr_e[k+s] = rv_w;
            pa_e[k+s]  = rv_a;
            pwd_e[k+s] = rv_d;
          end
          pen_e[k+2] = 1;
          rv_e[k+3]  = 1;
          re_e[k+3]  = 0;
          rd_e[k+3]  = rv_w ? 32'h0 : pr_a[k+2];
        end else begin
          j = k + 1;
          while (rv_e[j]) j++;
          rv_e[j] = 1;
          re_e[j] = 1;
          rd_e[j] = 32'h0;
        end
      end
      tick();
      chk_cyc($sformatf("rnd%0d", k + 1), !setup_c[k+1], ps_e[k+1], pen_e[k+1], rv_e[k+1],
              re_e[k+1], rd_e[k+1], pwr_e[k+1], pa_e[k+1], pwd_e[k+1]);
    end

    drive(0, 0, 32'h0, 32'h0, 32'h0);
    for (int i = 0; i < 4; i++) tick();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
